hazard_unit_sb: RTL
===================

HAZARD_UNIT_SB -- requirements
Module: hazard_unit_sb

Interface
REQ-001 SHALL have parameters: REG_AW, 5, register-address width; MAX_OUT, 4, maximum outstanding long-latency ops (1..15).
REQ-002 SHALL have ports, in this order:
- clk, input, 1, single clock; all state on rising edge.
- reset, input, 1, synchronous active-high reset.
- Rs1D/Rs2D/RdD, input, REG_AW each, Decode source/destination addresses.
- LongOpD, input, 1, Decode holds a long-latency op.
- Rs1E/Rs2E/RdE, input, REG_AW each, Execute addresses.
- ResultSrcE, input, 2, Execute result select.
- PCSrcE, input, 1, taken branch/jump.
- LongStartE, input, 1, long op accepted by the unit this cycle.
- RdM, input, REG_AW; RegWriteM, input, 1, Memory-stage writeback.
- RdW, input, REG_AW; RegWriteW, input, 1, Writeback stage.
- LongDoneW, input, 1; LongRdW, input, REG_AW, long-op completion.
- StallF, StallD, FlushD, FlushE, output, 1 each.
- ForwardAE, ForwardBE, output, 2 each.
- SbError, output, 1, sticky scoreboard error.
- StallCnt, FlushCnt, output, 32 each, performance counters.

Function
REQ-003 Forwarding SHALL be combinational: ForwardAE is FWD_MEM when Rs1E==RdM, RegWriteM=1 and Rs1E!=0; otherwise FWD_WB when Rs1E==RdW, RegWriteW=1 and Rs1E!=0; otherwise FWD_NONE. ForwardBE SHALL apply the same rule to Rs2E.
REQ-004 lwStall SHALL be asserted when ResultSrcE==RES_LOAD, RdE!=0, and (Rs1D==RdE or Rs2D==RdE).
REQ-005 The scoreboard SHALL hold one busy bit per register. Bit 0 SHALL stay 0.
REQ-006 A busy bit SHALL be set on the clock after LongStartE=1 with RdE!=0. It SHALL be cleared on the clock after LongDoneW=1 for LongRdW.
REQ-007 If set and clear hit the same register in the same cycle, the set SHALL win.
REQ-008 sbStall SHALL be asserted when busy[Rs1D], busy[Rs2D] or busy[RdD] is 1 for a nonzero address. The RdD check prevents WAW hazards.
REQ-009 The outstanding counter SHALL:
- increment on LongStartE;
- decrement on LongDoneW;
- hold when both occur in the same cycle;
- saturate at 0 and at MAX_OUT.
REQ-010 fullStall SHALL be asserted when LongOpD=1 and count==MAX_OUT.
REQ-011 With anyStall = lwStall | sbStall | fullStall:
- StallF = StallD = anyStall & ~PCSrcE (a flushed Decode instruction does not stall);
- FlushD = PCSrcE;
- FlushE = anyStall | PCSrcE.
REQ-012 SbError SHALL set when LongDoneW=1 for a register whose busy bit is 0, or on a counter under/overflow attempt. It SHALL stay set until reset.
REQ-013 The hazard outputs SHALL have zero cycle latency from their inputs. Scoreboard and counter effects SHALL be visible on the cycle after the triggering event.

Reset
REQ-014 reset SHALL clear every busy bit, the outstanding counter, SbError, StallCnt and FlushCnt on the next rising edge.
REQ-015 While reset is high, StallF, StallD, FlushD and FlushE SHALL follow their combinational equations on the cleared state.
REQ-016 A reset during outstanding long ops SHALL discard them. A later LongDoneW for a discarded op SHALL set SbError.

Configuration
REQ-017 With HAZARD_PERF_EN defined:
- StallCnt SHALL increment on each cycle with StallD=1;
- FlushCnt SHALL increment on each cycle with FlushD|FlushE=1;
- both SHALL saturate at 0xFFFFFFFF.
REQ-018 Without HAZARD_PERF_EN, StallCnt and FlushCnt SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-019 A shared package hazard_pkg SHALL define FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and RES_LOAD=2'b01.
REQ-020 The busy array, the outstanding counter and the SbError logic SHALL form the sub-module hazard_scoreboard. The top level SHALL hold forwarding, stall/flush logic and the performance counters.

Verification
REQ-021 Forwarding priority: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=2'b10; same with Rs1E=0 -> 2'b00.
REQ-022 Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Same with RdE=0 -> no stall.
REQ-023 Scoreboard: LongStartE, RdE=9 -> next cycle Rs1D=9 stalls. LongDoneW, LongRdW=9 -> stall drops the following cycle. Simultaneous start and done on reg 9 -> stays busy.
REQ-024 Capacity: MAX_OUT=4, four starts, then LongOpD=1 -> StallD=1. One LongDoneW -> StallD=0 next cycle.
REQ-025 Branch over stall: PCSrcE=1 together with lwStall -> StallF=StallD=0, FlushD=FlushE=1.
REQ-026 Reset mid-operation: two ops outstanding, reset pulse -> busy bits and count are 0. Stray LongDoneW -> SbError=1. With HAZARD_PERF_EN, the counters match the stall/flush cycle totals.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forwarding selects and result-source codes.
package hazard_pkg;

  typedef logic [1:0] fwd_t;

  localparam fwd_t       FWD_NONE = 2'b00;
  localparam fwd_t       FWD_WB   = 2'b01;
  localparam fwd_t       FWD_MEM  = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Decode-side register addresses and long-op strobes that the top hands to the scoreboard.
interface hazard_unit_sb_if #(
    parameter int REG_AW = 5
);
    // long_start and long_done are single-cycle strobes with no back-pressure:
    // an event counts in every cycle its strobe is high, qualified by start_rd / done_rd.
    logic [REG_AW-1:0] rs1d;
    logic [REG_AW-1:0] rs2d;
    logic [REG_AW-1:0] rdd;
    logic              long_op;
    logic              long_start;
    logic [REG_AW-1:0] start_rd;
    logic              long_done;
    logic [REG_AW-1:0] done_rd;

    modport master (
        output rs1d, rs2d, rdd, long_op, long_start, start_rd, long_done, done_rd
    );

    modport slave (
        input rs1d, rs2d, rdd, long_op, long_start, start_rd, long_done, done_rd
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register busy bits, outstanding long-op counter and sticky error flag.
import hazard_pkg::*;

module hazard_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int MAX_OUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    hazard_unit_sb_if.slave        req,
    output logic                   sb_stall,
    output logic                   full_stall,
    output logic                   sb_error
);

    localparam int             NREG  = 1 << REG_AW;
    localparam int             CW    = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0]  MAX_C = CW'(MAX_OUT);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [CW-1:0]   count;
    logic            stray_done;
    logic            overflow;
    logic            underflow;

    // Clear is applied first so a same-cycle set on the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (req.long_done)
            busy_nxt[req.done_rd] = 1'b0;
        if (req.long_start && (req.start_rd != '0))
            busy_nxt[req.start_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign stray_done = req.long_done && !busy[req.done_rd];
    assign overflow   = req.long_start && !req.long_done && (count == MAX_C);
    assign underflow  = req.long_done && !req.long_start && (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            count    <= '0;
            sb_error <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (req.long_start && !req.long_done && !overflow)
                count <= count + CW'(1);
            else if (req.long_done && !req.long_start && !underflow)
                count <= count - CW'(1);
            if (stray_done || overflow || underflow)
                sb_error <= 1'b1;
        end
    end

    // The RdD term blocks a second write to a register still owed by a long op.
    assign sb_stall = ((req.rs1d != '0) && busy[req.rs1d]) ||
                      ((req.rs2d != '0) && busy[req.rs2d]) ||
                      ((req.rdd  != '0) && busy[req.rdd]);

    assign full_stall = req.long_op && (count == MAX_C);

endmodule

// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit: forwarding, load-use / scoreboard / capacity stalls, flushes.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
import hazard_pkg::*;

module hazard_unit_sb #(
    parameter int REG_AW  = 5,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              LongOpD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              LongStartE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    input  logic              LongDoneW,
    input  logic [REG_AW-1:0] LongRdW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              SbError,
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt
);

    logic lw_stall;
    logic sb_stall;
    logic full_stall;
    logic any_stall;

    hazard_unit_sb_if #(.REG_AW(REG_AW)) sb_req ();

    assign sb_req.rs1d       = Rs1D;
    assign sb_req.rs2d       = Rs2D;
    assign sb_req.rdd        = RdD;
    assign sb_req.long_op    = LongOpD;
    assign sb_req.long_start = LongStartE;
    assign sb_req.start_rd   = RdE;
    assign sb_req.long_done  = LongDoneW;
    assign sb_req.done_rd    = LongRdW;

    hazard_scoreboard #(
        .REG_AW  (REG_AW),
        .MAX_OUT (MAX_OUT)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .req        (sb_req),
        .sb_stall   (sb_stall),
        .full_stall (full_stall),
        .sb_error   (SbError)
    );

    // Memory stage holds the younger result, so it beats Writeback.
    always_comb begin
        ForwardAE = FWD_NONE;
        if ((Rs1E != '0) && RegWriteM && (Rs1E == RdM))
            ForwardAE = FWD_MEM;
        else if ((Rs1E != '0) && RegWriteW && (Rs1E == RdW))
            ForwardAE = FWD_WB;

        ForwardBE = FWD_NONE;
        if ((Rs2E != '0) && RegWriteM && (Rs2E == RdM))
            ForwardBE = FWD_MEM;
        else if ((Rs2E != '0) && RegWriteW && (Rs2E == RdW))
            ForwardBE = FWD_WB;
    end

    assign lw_stall  = (ResultSrcE == RES_LOAD) && (RdE != '0) &&
                       ((Rs1D == RdE) || (Rs2D == RdE));
    assign any_stall = lw_stall | sb_stall | full_stall;

    // A taken branch squashes Decode, so holding it would only lose the redirect.
    assign StallF = any_stall & ~PCSrcE;
    assign StallD = any_stall & ~PCSrcE;
    assign FlushD = PCSrcE;
    assign FlushE = any_stall | PCSrcE;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && (StallCnt != 32'hFFFF_FFFF))
                StallCnt <= StallCnt + 32'd1;
            if ((FlushD || FlushE) && (FlushCnt != 32'hFFFF_FFFF))
                FlushCnt <= FlushCnt + 32'd1;
        end
    end
`else
    assign StallCnt = 32'd0;
    assign FlushCnt = 32'd0;
`endif

endmodule
